poly_add_mod: RTL
=================

Name: poly_add_mod

Overview:
- Stage directly downstream of multiplier_top in the fv_enc datapath.
- Consumes the product stream z, one coefficient per cycle. z_rdy is advisory only, because the multiplier never stalls.
- Joins z with a second operand stream e (error plus delta*m, precomputed upstream) and emits c = (z + e) mod Q with AXI-stream backpressure.
- A polynomial-deep FIFO absorbs z while e or the sink stalls.

Parameters:
- N, 16: coefficients per polynomial.
- QW, 64: coefficient bit-width.
- Q, 64'hFFFF_FFFF_0000_0001: modulus. Must satisfy 2 <= Q < 2^QW.
- DEPTH, N: z FIFO depth. Power of two, >= 2.

Ports:
- clk, input, 1: system clock, rising edge.
- a_rst_n, input, 1: reset, asynchronous assert, active low.
- z_vld, input, 1: product coefficient valid. Always accepted unless the FIFO is full.
- z_rdy, output, 1: high when the FIFO is not full. Status only; the producer ignores it.
- z, input, QW: product coefficient, < Q.
- z_last, input, 1: last coefficient of a polynomial.
- e_vld, input, 1: operand valid.
- e_rdy, output, 1: operand accepted.
- e, input, QW: operand coefficient, < Q.
- e_last, input, 1: last operand coefficient.
- c_vld, output, 1: result valid.
- c_rdy, input, 1: sink ready.
- c, output, QW: result coefficient.
- c_last, output, 1: last result coefficient.
- ovf, output, 1: sticky; a z beat was dropped.
- frm_err, output, 1: sticky; a last-flag mismatch or polynomial length != N was seen.

Behaviour:
- Reset (a_rst_n low, asynchronous):
  - FIFO empty, pointers 0.
  - c_vld = 0, c = 0, c_last = 0.
  - ovf = 0, frm_err = 0.
  - Coefficient counter = 0.
  - z_rdy = 1 and e_rdy = 0 while in reset.
  - Reset mid-polynomial discards FIFO contents and the output register. Release is treated as a polynomial boundary.
- FIFO push:
  - Push {z_last, z} when z_vld && !full.
  - If z_vld && full && !pop: beat dropped, ovf set (sticky until reset).
  - Simultaneous push and pop on a full FIFO: push accepted, occupancy unchanged.
- FIFO read is registered: a beat written at cycle t is poppable no earlier than t+1.
- Join / handshake:
  - ld = !c_vld || c_rdy (output register free or draining).
  - e_rdy = !empty && ld.
  - pop = e_vld && e_rdy. On pop, the FIFO head and e are consumed together.
  - No combinational path from e_vld to e_rdy. There is one from c_rdy to e_rdy.
- Arithmetic:
  - s = head + e, computed at QW+1 bits.
  - c_next = (s >= Q) ? s - Q : s, truncated to QW bits.
  - Both operands are < Q, so a single conditional subtract suffices.
  - Out-of-range inputs give an unspecified result. No flag is raised for them.
- Output register:
  - On pop: c <= c_next, c_last <= head_last, c_vld <= 1.
  - Else if c_rdy: c_vld <= 0.
  - c, c_last and c_vld hold stable while c_vld && !c_rdy.
- Latency:
  - z accepted at cycle t gives c_vld at t+2 earliest (e valid and sink ready).
  - Sustained throughput is 1 coefficient per cycle.
- Framing:
  - Counter increments on each pop. It wraps to 0 on a pop with head_last.
  - frm_err is set on a pop if head_last != e_last.
  - frm_err is set if head_last is high while count != N-1.
  - frm_err is set if count == N-1 and head_last is low.
  - c_last follows head_last even on an error.
- Empty FIFO with e_vld high: e_rdy stays 0 and e waits.
- A full sink (c_rdy low) stalls pops. The FIFO keeps filling from z.

Decomposition:
- fv_enc_pkg holds:
  - coef_t (logic [QW-1:0]);
  - the Q constant;
  - add_mod function (QW+1-bit add, conditional subtract);
  - beat_t struct {last, coef}.
- Sub-module coef_fifo: sync FIFO of beat_t, DEPTH entries.
  - Ports: push, pop, wdata, rdata, full, empty.
  - Async active-low reset, registered read.
- Join, add_mod, output register and framing checker stay in the top.

Test Plan:
- Modular wrap: z=Q-1, e=2 -> c=1. Then z=5, e=7 -> c=12. Then z=Q-1, e=1 -> c=0. c_last=0 on all three, ovf=0.
- Full polynomial, e and c_rdy always high:
  - Drive 16 beats z=i, e=100+i, last on i=15.
  - Expect c=100+2i. First c_vld two cycles after first z. c_last on beat 15 only. frm_err=0.
- e stalled:
  - Hold e_vld=0 and push 16 z beats -> FIFO full, z_rdy=0, ovf=0.
  - Push a 17th beat -> ovf=1.
  - Release e -> exactly the first 16 beats are emitted, in order.
- Sink backpressure: toggle c_rdy 1,0,0,1 during a stream -> c holds stable while stalled, no beat lost or duplicated, e_rdy=0 on stall cycles.
- Framing:
  - Assert e_last on beat 10 while z_last is on beat 15 -> frm_err=1 at the beat-10 pop. frm_err stays set.
  - A following correct polynomial still produces correct c values.
- Reset mid-stream:
  - Assert a_rst_n low asynchronously after 7 beats -> c_vld=0, ovf and frm_err cleared, FIFO empty immediately.
  - After release, a fresh 16-beat polynomial gives a correct result with frm_err=0.

Source files
------------

// File: rtl/fv_enc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fv_enc_pkg
//  Brief    : Shared types, modulus constant and modular-add helper for fv_enc
//  Revision : 1.0 - initial release
// ============================================================================
package fv_enc_pkg;

   localparam int unsigned FV_QW = 64;
   localparam logic [FV_QW-1:0] FV_Q = 64'hFFFF_FFFF_0000_0001;

   typedef logic [FV_QW-1:0] coef_t;

   typedef struct packed {
      logic  last;
      coef_t coef;
   } beat_t;

   // Both operands must already be reduced below q, so one subtract is enough.
   function automatic coef_t add_mod(input coef_t a, input coef_t b, input coef_t q);
      logic [FV_QW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) begin
         s = s - {1'b0, q};
      end
      return s[FV_QW-1:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/coef_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : coef_fifo
//  Brief    : Synchronous FIFO of beat_t entries with registered storage
//  Revision : 1.0 - initial release
// ============================================================================
module coef_fifo
   import fv_enc_pkg::*;
#(
   parameter int unsigned DEPTH = 16
)
(
   input  logic  clk,
   input  logic  a_rst_n,
   input  logic  push,
   input  logic  pop,
   input  beat_t wdata,
   output beat_t rdata,
   output logic  full,
   output logic  empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   beat_t         mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/poly_add_mod.sv
`default_nettype none
// ============================================================================
//  Module   : poly_add_mod
//  Brief    : Joins product stream z with operand stream e, emits (z+e) mod Q
//  Revision : 1.0 - initial release
// ============================================================================
module poly_add_mod
   import fv_enc_pkg::*;
#(
   parameter int unsigned      N     = 16,
   parameter int unsigned      QW    = FV_QW,   // must match the package coefficient width
   parameter logic [QW-1:0]    Q     = FV_Q,
   parameter int unsigned      DEPTH = N
)
(
   input  logic          clk,
   input  logic          a_rst_n,
   input  logic          z_vld,
   output logic          z_rdy,
   input  logic [QW-1:0] z,
   input  logic          z_last,
   input  logic          e_vld,
   output logic          e_rdy,
   input  logic [QW-1:0] e,
   input  logic          e_last,
   output logic          c_vld,
   input  logic          c_rdy,
   output logic [QW-1:0] c,
   output logic          c_last,
   output logic          ovf,
   output logic          frm_err
);

   localparam int unsigned CW       = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   beat_t         wbeat;
   beat_t         head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          ld;
   logic          frm_hit;
   logic [QW-1:0] c_next;

   logic          c_vld_q, c_vld_d;
   logic [QW-1:0] c_q, c_d;
   logic          c_last_q, c_last_d;
   logic          ovf_q, ovf_d;
   logic          frm_err_q, frm_err_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // A full FIFO still accepts z when the head leaves in the same cycle.
   assign ld    = !c_vld_q || c_rdy;
   assign e_rdy = !fifo_empty && ld;
   assign pop   = e_vld && e_rdy;
   assign push  = z_vld && (!fifo_full || pop);
   assign z_rdy = !fifo_full;

   always_comb begin
      wbeat      = '0;
      wbeat.last = z_last;
      wbeat.coef = z;
   end

   coef_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .push    (push),
      .pop     (pop),
      .wdata   (wbeat),
      .rdata   (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign c_next = add_mod(head.coef, e, Q);

   assign frm_hit = (head.last != e_last)
                 || ( head.last && (cnt_q != LAST_CNT))
                 || (!head.last && (cnt_q == LAST_CNT));

   always_comb begin
      c_vld_d   = c_vld_q;
      c_d       = c_q;
      c_last_d  = c_last_q;
      ovf_d     = ovf_q;
      frm_err_d = frm_err_q;
      cnt_d     = cnt_q;
      if (pop) begin
         c_d      = c_next;
         c_last_d = head.last;
         c_vld_d  = 1'b1;
         cnt_d    = head.last ? '0 : cnt_q + 1'b1;
         if (frm_hit) begin
            frm_err_d = 1'b1;
         end
      end else if (c_rdy) begin
         c_vld_d = 1'b0;
      end
      if (z_vld && fifo_full && !pop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         c_vld_q   <= 1'b0;
         c_q       <= '0;
         c_last_q  <= 1'b0;
         ovf_q     <= 1'b0;
         frm_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         c_vld_q   <= c_vld_d;
         c_q       <= c_d;
         c_last_q  <= c_last_d;
         ovf_q     <= ovf_d;
         frm_err_q <= frm_err_d;
         cnt_q     <= cnt_d;
      end
   end

   assign c_vld   = c_vld_q;
   assign c       = c_q;
   assign c_last  = c_last_q;
   assign ovf     = ovf_q;
   assign frm_err = frm_err_q;

endmodule
`default_nettype wire
